// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral with a STATUS/CONTROL/DATA register block on a simple bus.
// SPI pins are oversampled on clk through 2-flop synchronizers.
module spi_peripheral #(
    parameter logic [31:0] ADDR = 32'hd100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    input  logic        i_wen,
    input  logic        i_ren,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_active,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StAbort
    } state_e;

    state_e      r_state;

    logic        r_sclk_meta;
    logic        r_sclk_sync;
    logic        r_sclk_prev;
    logic        r_cs_meta;
    logic        r_cs_sync;
    logic        r_mosi_meta;
    logic        r_mosi_sync;
    logic [1:0]  r_sync_vld;
    logic        r_armed;
    logic        r_sel_prev;

    logic        r_enable;
    logic [7:0]  r_fill;
    logic [7:0]  r_tx_hold;
    logic        r_tx_empty;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_overrun;

    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift_in;
    logic [7:0]  r_shift_out;
    logic        r_byte_done;

    logic        w_hit_status;
    logic        w_hit_control;
    logic        w_hit_data;
    logic        w_ovr_clr;
    logic        w_wr_data;
    logic        w_rd_data;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_selected;
    logic        w_start;
    logic        w_rx_done;
    logic        w_reload;
    logic        w_load;
    logic        w_busy;
    logic [7:0]  w_load_byte;
    logic [7:0]  w_rx_byte;
    logic        w_unused;

    assign w_hit_status  = (i_addr == ADDR);
    assign w_hit_control = (i_addr == ADDR + 32'd4);
    assign w_hit_data    = (i_addr == ADDR + 32'd8);

    assign w_ovr_clr = i_wen & w_hit_status & i_wmask[0] & i_wdata[2];
    assign w_wr_data = i_wen & w_hit_data & i_wmask[0];
    assign w_rd_data = i_ren & w_hit_data;

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_selected  = r_enable & ~r_cs_sync;

    // Starting needs cs_n to have been genuinely seen high since reset, so a
    // controller still mid-frame after reset is ignored until it re-frames.
    assign w_start   = (r_state == StIdle) & w_selected & ~r_sel_prev & r_armed;
    assign w_rx_done = (r_state == StShift) & w_selected & w_sclk_rise & (r_bit_cnt == 3'd7);
    assign w_reload  = (r_state == StShift) & w_selected & w_sclk_fall & (r_bit_cnt == 3'd0)
                       & r_byte_done;
    assign w_load    = w_start | w_reload;

    assign w_load_byte = r_tx_empty ? r_fill : r_tx_hold;
    assign w_rx_byte   = {r_shift_in[6:0], r_mosi_sync};
    assign w_busy      = (r_state == StShift) && (r_bit_cnt != 3'd0);

    assign o_ready   = 1'b1;
    assign o_active  = w_hit_status | w_hit_control | w_hit_data;
    assign o_miso_oe = w_selected;
    assign o_miso    = w_selected & r_shift_out[7];

    assign w_unused = ^{i_wdata[31:16], i_wmask[3:2]};

    always_comb begin
        o_rdata = 32'd0;
        if (w_hit_status) begin
            o_rdata = {27'd0, w_busy, w_selected, r_overrun, r_tx_empty, r_rx_valid};
        end else if (w_hit_control) begin
            o_rdata = {16'd0, r_fill, 7'd0, r_enable};
        end else if (w_hit_data) begin
            o_rdata = {24'd0, r_rx_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_sync_vld  <= 2'b00;
            r_armed     <= 1'b0;
            r_sel_prev  <= 1'b0;
            r_enable    <= 1'b0;
            r_fill      <= 8'd0;
            r_tx_hold   <= 8'd0;
            r_tx_empty  <= 1'b1;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 8'd0;
            r_shift_out <= 8'd0;
            r_byte_done <= 1'b0;
        end else begin
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= i_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_sync_vld  <= {r_sync_vld[0], 1'b1};
            r_sel_prev  <= w_selected;
            if (r_sync_vld[1] && r_cs_sync) begin
                r_armed <= 1'b1;
            end

            if (i_wen && w_hit_control) begin
                if (i_wmask[0]) r_enable <= i_wdata[0];
                if (i_wmask[1]) r_fill <= i_wdata[15:8];
            end

            // A DATA write in a load cycle wins tx_empty; the load used the old byte.
            if (w_load) r_tx_empty <= 1'b1;
            if (w_wr_data) begin
                r_tx_hold  <= i_wdata[7:0];
                r_tx_empty <= 1'b0;
            end

            if (w_rd_data) r_rx_valid <= 1'b0;
            if (w_ovr_clr) r_overrun <= 1'b0;
            if (w_rx_done) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_rd_data) r_overrun <= 1'b1;
            end

            if (!r_enable) begin
                r_state   <= StIdle;
                r_bit_cnt <= 3'd0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_start) begin
                            r_state     <= StShift;
                            r_shift_out <= w_load_byte;
                            r_shift_in  <= 8'd0;
                            r_bit_cnt   <= 3'd0;
                            r_byte_done <= 1'b0;
                        end
                    end
                    StShift: begin
                        if (!w_selected) begin
                            r_state <= (r_bit_cnt == 3'd0) ? StIdle : StAbort;
                        end else if (w_sclk_rise) begin
                            r_shift_in <= w_rx_byte;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
                        end else if (w_sclk_fall) begin
                            if (w_reload) begin
                                r_shift_out <= w_load_byte;
                            end else begin
                                r_shift_out <= {r_shift_out[6:0], 1'b0};
                            end
                        end
                    end
                    StAbort: begin
                        r_state   <= StIdle;
                        r_bit_cnt <= 3'd0;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: register vector table, then framed SPI transfers
// driven as a mode-0 controller at sclk = clk/8.
module tb_spi_peripheral;

    localparam logic [31:0] A = 32'hd100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wen;
        logic        ren;
        logic [31:0] exp_rdata;
        logic        exp_active;
    } vec_t;

    vec_t vecs[$];

    spi_peripheral #(.ADDR(A)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .i_wmask  (wmask),
        .i_wen    (wen),
        .i_ren    (ren),
        .o_rdata  (rdata),
        .o_ready  (ready),
        .o_active (active),
        .i_sclk   (sclk),
        .i_cs_n   (cs_n),
        .i_mosi   (mosi),
        .o_miso   (miso),
        .o_miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop_chk(input string nm, input logic [31:0] act);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %h, want nothing queued", nm, act);
        end else begin
            e = sb_q.pop_front();
            chk(nm, act, e);
        end
    endtask

    task automatic bus_rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        sb_q.push_back(exp);
        @(negedge clk);
        addr = a;
        ren  = 1'b1;
        wen  = 1'b0;
        #1 d = rdata;
        @(posedge clk);
        #1 ren = 1'b0;
        sb_pop_chk(nm, d);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wmask = m;
        wen   = 1'b1;
        ren   = 1'b0;
        @(posedge clk);
        #1 wen = 1'b0;
    endtask

    // Clocks the top nbits of tx; optionally reads DATA in the clk cycle in which
    // the peripheral completes the 8th rising edge.
    task automatic spi_clock(input logic [7:0] tx, input int nbits, input bit rd_last,
                             output logic [7:0] got, output logic [31:0] rd);
        got = 8'd0;
        rd  = 32'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            sclk   = 1'b1;
            got[i] = miso;
            if (rd_last && i == 0) begin
                repeat (2) @(negedge clk);
                addr = A + 32'd8;
                ren  = 1'b1;
                #1 rd = rdata;
                @(posedge clk);
                #1 ren = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp_miso, input string nm);
        logic [7:0]  got;
        logic [31:0] rd;
        sb_q.push_back({24'd0, exp_miso});
        spi_clock(tx, 8, 1'b0, got, rd);
        sb_pop_chk(nm, {24'd0, got});
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  got;
        logic [31:0] rd;

        rst = 1'b1; addr = 32'd0; wdata = 32'd0; wmask = 4'd0; wen = 1'b0; ren = 1'b0;
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_miso", {31'd0, miso}, 32'd0);
        chk("reset_miso_oe", {31'd0, miso_oe}, 32'd0);

        vecs.push_back('{A,            32'h0,         4'h0, 1'b0, 1'b1, 32'h2,      1'b1});
        vecs.push_back('{A + 32'd4,    32'h0,         4'h0, 1'b0, 1'b1, 32'h0,      1'b1});
        vecs.push_back('{A + 32'd8,    32'h0,         4'h0, 1'b0, 1'b1, 32'h0,      1'b1});
        vecs.push_back('{A + 32'd12,   32'h0,         4'h0, 1'b0, 1'b1, 32'h0,      1'b0});
        vecs.push_back('{A - 32'd4,    32'h0,         4'h0, 1'b0, 1'b1, 32'h0,      1'b0});
        vecs.push_back('{A + 32'd9,    32'h0,         4'h0, 1'b0, 1'b1, 32'h0,      1'b0});
        vecs.push_back('{A + 32'd4,    32'hFFFF_AB00, 4'h2, 1'b1, 1'b0, 32'h0,      1'b1});
        vecs.push_back('{A + 32'd4,    32'h0,         4'h0, 1'b0, 1'b1, 32'hAB00,   1'b1});
        vecs.push_back('{A + 32'd4,    32'h0000_0001, 4'h1, 1'b1, 1'b0, 32'hAB00,   1'b1});
        vecs.push_back('{A + 32'd4,    32'h0,         4'h0, 1'b0, 1'b1, 32'hAB01,   1'b1});
        vecs.push_back('{A + 32'd4,    32'hFFFF_FFFE, 4'hC, 1'b1, 1'b0, 32'hAB01,   1'b1});
        vecs.push_back('{A + 32'd4,    32'h0,         4'h0, 1'b0, 1'b1, 32'hAB01,   1'b1});
        vecs.push_back('{A,            32'h0,         4'h0, 1'b0, 1'b1, 32'h2,      1'b1});
        vecs.push_back('{A + 32'd8,    32'h1234_56A5, 4'h1, 1'b1, 1'b0, 32'h0,      1'b1});
        vecs.push_back('{A,            32'h0,         4'h0, 1'b0, 1'b1, 32'h0,      1'b1});
        vecs.push_back('{A + 32'd8,    32'h0000_0077, 4'hE, 1'b1, 1'b0, 32'h0,      1'b1});
        vecs.push_back('{A,            32'h0,         4'h0, 1'b0, 1'b1, 32'h0,      1'b1});

        foreach (vecs[k]) begin
            @(negedge clk);
            addr  = vecs[k].addr;
            wdata = vecs[k].wdata;
            wmask = vecs[k].wmask;
            wen   = vecs[k].wen;
            ren   = vecs[k].ren;
            sb_q.push_back(vecs[k].exp_rdata);
            #1;
            sb_pop_chk($sformatf("vec%0d_rdata", k), rdata);
            chk($sformatf("vec%0d_active", k), {31'd0, active}, {31'd0, vecs[k].exp_active});
            chk($sformatf("vec%0d_ready", k), {31'd0, ready}, 32'd1);
            @(posedge clk);
            #1 wen = 1'b0;
            ren = 1'b0;
        end

        // Basic transfer: tx_hold A5 out, 3C in.
        cs_low();
        chk("basic_miso_oe", {31'd0, miso_oe}, 32'd1);
        spi_byte(8'h3C, 8'hA5, "basic_miso");
        cs_high();
        chk("basic_miso_oe_off", {31'd0, miso_oe}, 32'd0);
        bus_rd_chk(A, 32'h3, "basic_status");
        bus_rd_chk(A + 32'd8, 32'h3C, "basic_rx");
        bus_rd_chk(A, 32'h2, "basic_status_cleared");

        // Fill byte, two bytes without reading DATA.
        bus_wr(A + 32'd4, 32'h0000_FF01, 4'h3);
        cs_low();
        spi_byte(8'h55, 8'hFF, "fill_miso0");
        spi_byte(8'hAA, 8'hFF, "fill_miso1");
        cs_high();
        bus_rd_chk(A, 32'h7, "fill_status_overrun");
        bus_rd_chk(A + 32'd8, 32'hAA, "fill_rx");
        bus_rd_chk(A, 32'h6, "fill_status_read");
        bus_wr(A, 32'h4, 4'h2);
        bus_rd_chk(A, 32'h6, "ovr_clear_masked");
        bus_wr(A, 32'h4, 4'h1);
        bus_rd_chk(A, 32'h2, "ovr_cleared");

        // Back-to-back bytes with a refill between them.
        bus_wr(A + 32'd8, 32'h11, 4'h1);
        cs_low();
        bus_wr(A + 32'd8, 32'h22, 4'h1);
        bus_rd_chk(A, 32'h8, "b2b_status_hold");
        spi_byte(8'h01, 8'h11, "b2b_miso0");
        bus_rd_chk(A + 32'd8, 32'h01, "b2b_rx0");
        spi_byte(8'h02, 8'h22, "b2b_miso1");
        bus_rd_chk(A + 32'd8, 32'h02, "b2b_rx1");
        cs_high();
        bus_rd_chk(A, 32'h2, "b2b_status");

        // Abort after 5 edges, then an aligned full byte.
        cs_low();
        spi_clock(8'hF0, 5, 1'b0, got, rd);
        cs_high();
        bus_rd_chk(A, 32'h2, "abort_status");
        bus_rd_chk(A + 32'd8, 32'h02, "abort_rx_kept");
        bus_wr(A + 32'd8, 32'hC3, 4'h1);
        cs_low();
        spi_byte(8'h5A, 8'hC3, "post_abort_miso");
        cs_high();
        bus_rd_chk(A + 32'd8, 32'h5A, "post_abort_rx");

        // DATA read in the cycle that completes the second byte.
        cs_low();
        spi_byte(8'h81, 8'hFF, "simul_miso0");
        spi_clock(8'h7E, 8, 1'b1, got, rd);
        chk("simul_rd_old", rd, 32'h81);
        cs_high();
        bus_rd_chk(A, 32'h3, "simul_status");
        bus_rd_chk(A + 32'd8, 32'h7E, "simul_rx");

        // Reset during bit 3 with cs_n still low.
        cs_low();
        spi_clock(8'hE7, 3, 1'b0, got, rd);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        bus_rd_chk(A, 32'h2, "rst_status");
        bus_rd_chk(A + 32'd8, 32'h0, "rst_rx");
        bus_wr(A + 32'd4, 32'h0000_5C01, 4'h3);
        repeat (2) @(negedge clk);
        chk("rst_sel_oe", {31'd0, miso_oe}, 32'd1);
        spi_clock(8'hFF, 8, 1'b0, got, rd);
        bus_rd_chk(A, 32'hA, "rst_no_resume");
        cs_high();
        cs_low();
        spi_byte(8'h96, 8'h5C, "rst_next_miso");
        cs_high();
        bus_rd_chk(A, 32'h3, "rst_next_status");
        bus_rd_chk(A + 32'd8, 32'h96, "rst_next_rx");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter ADDR, default 32'hd100: base address of the register block.
REQ-002 clk  input  1: single system clock; all logic is on its rising edge.
REQ-003 rst  input  1: synchronous, active-high reset.
REQ-004 addr  input  32: bus address.
REQ-005 wdata  input  32: bus write data.
REQ-006 wmask  input  4: byte-lane write enables.
REQ-007 wen  input  1: write strobe.
REQ-008 ren  input  1: read strobe.
REQ-009 rdata  output  32: combinational read data; 0 for unmapped addresses.
REQ-010 ready  output  1: tied to 1.
REQ-011 active  output  1: high when addr equals ADDR+0, ADDR+4 or ADDR+8.
REQ-012 sclk  input  1: SPI clock from the controller, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-013 cs_n  input  1: chip select, active-low, asynchronous.
REQ-014 mosi  input  1: serial data in, MSB first.
REQ-015 miso  output  1: serial data out, MSB first.
REQ-016 miso_oe  output  1: output enable for the miso pad.

Function
REQ-017 Registers SHALL be as follows.
- STATUS at ADDR+0: bit0 rx_valid, bit1 tx_empty, bit2 overrun, bit3 selected, bit4 busy; other bits read 0.
- CONTROL at ADDR+4: bit0 enable, bits[15:8] fill byte; other bits read 0; writes are per-lane via wmask.
- DATA at ADDR+8: a write with wmask[0]=1 loads tx_hold from wdata[7:0] and clears tx_empty; a read returns {24'b0, rx_data}.
REQ-018 A write to STATUS with wmask[0]=1 and wdata[2]=1 SHALL clear overrun; all other STATUS bits are read-only.
REQ-019 A cycle with ren=1 and addr=ADDR+8 SHALL clear rx_valid at the next edge.
REQ-020 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized values. sclk is supported up to clk/8.
REQ-021 selected = enable AND synchronized cs_n==0; miso_oe = selected; miso = shift_out[7] when selected, else 0.
REQ-022 The FSM SHALL have states IDLE, SHIFT and ABORT.
- IDLE->SHIFT on the selected rising edge: shift_out loads the byte, bit_cnt=0, shift_in=0.
- SHIFT->IDLE on deselect with bit_cnt==0.
- SHIFT->ABORT on deselect with bit_cnt!=0.
- ABORT->IDLE after one cycle.
REQ-023 Byte load SHALL take tx_hold if tx_empty=0, else the CONTROL fill byte; every load sets tx_empty=1.
REQ-024 In SHIFT, each synchronized sclk rising edge SHALL perform shift_in={shift_in[6:0],mosi} and bit_cnt+1.
REQ-025 On the rising edge that completes bit 8:
- rx_data is written with the full byte and rx_valid is set;
- overrun is set if rx_valid was already 1 and is not being cleared in the same cycle;
- bit_cnt wraps to 0.
REQ-026 In SHIFT, a falling sclk edge SHALL reload shift_out (REQ-023) when bit_cnt==0 and at least one byte has completed, and otherwise shift shift_out left by one, so the MSB of the next byte is presented before the next rising edge.
REQ-027 busy = (bit_cnt!=0) in SHIFT.
REQ-028 ABORT SHALL discard the partial byte: rx_data, rx_valid and overrun are unchanged, and bit_cnt=0.
REQ-029 Simultaneous events SHALL resolve as follows.
- DATA read in the byte-complete cycle: rx_valid stays 1, no overrun.
- DATA write in a load cycle: the load uses the old tx_hold or fill byte, tx_hold takes the new value, tx_empty=0.
- Overrun clear and overrun set in the same cycle: set wins.
REQ-030 enable=0 SHALL force the FSM to IDLE within one cycle; registers stay bus-accessible.
REQ-031 Bus writes SHALL take effect at the next clk edge; rdata SHALL have zero-cycle latency.

Reset
REQ-032 While rst=1 at a clk edge, the block SHALL set:
- control=0, tx_hold=0, rx_data=0;
- tx_empty=1, rx_valid=0, overrun=0;
- FSM=IDLE, bit_cnt=0, shift registers=0, synchronizers to idle (cs_n=1, sclk=0).
REQ-033 After reset, miso=0, miso_oe=0, ready=1, and STATUS reads 32'h2.
REQ-034 Reset asserted mid-byte SHALL abandon the transfer with no rx_valid set; a transfer resumes only after a fresh cs_n falling edge.

Verification
REQ-035 Basic transfer.
- Stimulus: enable=1, DATA write 8'hA5; controller sends 8'h3C at sclk=clk/8.
- Response: miso carries A5 MSB-first; rx_data=3C; STATUS=32'h3 (rx_valid=1, tx_empty=1) after cs_n rises.
REQ-036 Fill byte.
- Stimulus: fill=8'hFF, no DATA write; 2-byte transfer.
- Response: miso carries FF FF; second byte sets overrun=1 if DATA is not read between the bytes.
REQ-037 Back-to-back bytes.
- Stimulus: DATA write 8'h11, then write 8'h22 after the first load; 2-byte transfer 8'h01 8'h02.
- Response: miso carries 11 22; reading DATA after each byte returns 01 then 02; no overrun.
- Stimulus: cs_n rises after 5 sclk edges.
- Response: rx_valid stays 0, rx_data is unchanged, the next full transfer is byte-aligned.
REQ-039 Simultaneous read and completion.
- Stimulus: DATA read in the same clk cycle as the 8th rising edge.
- Response: rx_valid=1, overrun=0.
REQ-040 Reset mid-byte.
- Stimulus: rst pulsed during bit 3.
- Response: STATUS=32'h2, miso_oe=0; the next cs_n-framed byte is received correctly.
